mem_wb_stage: RTL and testbench

Pipeline register and write-back stage between MEM and the general-purpose register file. Captures the MEM-stage result on each rising clock edge, aligns and sign/zero-extends load data returning from the synchronous data RAM, and drives the register file's write port (waddr/wdata/we). Also owns the HI/LO register pair and exposes the WB-stage values for forwarding to EX.

---
 rtl/mem_wb_stage_pkg.sv | 35 +++
 rtl/mem_wb_stage_if.sv | 41 ++++
 rtl/mem_wb_stage_load_align.sv | 69 ++++++
 rtl/mem_wb_stage.sv | 76 +++++++
 tb/tb_mem_wb_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
// Shared definitions for the MEM/WB pipeline register: load-op encodings,
// datapath widths, the all-zero word and the stage-register record.
package mem_wb_stage_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } load_op_e;

   // One WB-stage slot. An all-zero value is a bubble (no writes pending).
   typedef struct packed {
      logic [REG_ADDR_W-1:0] waddr;
      logic [DATA_W-1:0]     wdata;
      logic                  we;
      load_op_e              load_op;
      logic [1:0]            addr_lo;
      logic [DATA_W-1:0]     rt_data;
      logic                  whilo;
      logic [DATA_W-1:0]     hi;
      logic [DATA_W-1:0]     lo;
   } stage_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
// Bundles the MEM-side inputs, the data-RAM read data and the WB-side
// outputs of mem_wb_stage.
//   slave  : the stage itself (consumes MEM/stall/RAM, drives wb_* and hi/lo)
//   master : whoever drives the MEM side and observes the write-back port
import mem_wb_stage_pkg::*;

interface mem_wb_stage_if;
   logic                  stall_mem;
   logic                  stall_wb;
   logic                  flush;
   logic [REG_ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_we;
   logic [2:0]            mem_load_op;
   logic [DATA_W-1:0]     mem_rt_data;
   logic                  mem_whilo;
   logic [DATA_W-1:0]     mem_hi;
   logic [DATA_W-1:0]     mem_lo;
   logic [DATA_W-1:0]     dram_rdata;
   logic [REG_ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0]     wb_wdata;
   logic                  wb_we;
   logic                  wb_whilo;
   logic [DATA_W-1:0]     wb_hi;
   logic [DATA_W-1:0]     wb_lo;
   logic [DATA_W-1:0]     hi_o;
   logic [DATA_W-1:0]     lo_o;

   modport slave (
      input  stall_mem, stall_wb, flush, mem_waddr, mem_wdata, mem_we,
             mem_load_op, mem_rt_data, mem_whilo, mem_hi, mem_lo, dram_rdata,
      output wb_waddr, wb_wdata, wb_we, wb_whilo, wb_hi, wb_lo, hi_o, lo_o
   );

   modport master (
      output stall_mem, stall_wb, flush, mem_waddr, mem_wdata, mem_we,
             mem_load_op, mem_rt_data, mem_whilo, mem_hi, mem_lo, dram_rdata,
      input  wb_waddr, wb_wdata, wb_we, wb_whilo, wb_hi, wb_lo, hi_o, lo_o
   );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align
// Purely combinational write-back data selection. Picks the byte/halfword
// of the returning RAM word (little-endian, lane chosen by addr_lo), sign-
// or zero-extends it, merges LWL/LWR with the old rt value, or passes the
// ALU result through for non-loads.
// Ports:
//   load_op    in  load-op encoding
//   addr_lo    in  low two bits of the load address
//   dram_rdata in  RAM read word
//   rt_data    in  old rt value for LWL/LWR
//   wdata      in  ALU/move result
//   wb_wdata   out register-file write data
import mem_wb_stage_pkg::*;

module load_align (
   input  load_op_e          load_op,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] dram_rdata,
   input  logic [DATA_W-1:0] rt_data,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] wb_wdata
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = dram_rdata[7:0];
      case (addr_lo)
         2'd0: sel_byte = dram_rdata[7:0];
         2'd1: sel_byte = dram_rdata[15:8];
         2'd2: sel_byte = dram_rdata[23:16];
         2'd3: sel_byte = dram_rdata[31:24];
         default: sel_byte = dram_rdata[7:0];
      endcase
      // Halfword lane uses only addr_lo[1]; misalignment is trapped upstream.
      sel_half = addr_lo[1] ? dram_rdata[31:16] : dram_rdata[15:0];
   end

   always_comb begin
      wb_wdata = wdata;
      case (load_op)
         LD_NONE: wb_wdata = wdata;
         LD_LB:   wb_wdata = {{24{sel_byte[7]}}, sel_byte};
         LD_LBU:  wb_wdata = {24'd0, sel_byte};
         LD_LH:   wb_wdata = {{16{sel_half[15]}}, sel_half};
         LD_LHU:  wb_wdata = {16'd0, sel_half};
         LD_LW:   wb_wdata = dram_rdata;
         LD_LWL: begin
            case (addr_lo)
               2'd0: wb_wdata = {dram_rdata[7:0],  rt_data[23:0]};
               2'd1: wb_wdata = {dram_rdata[15:0], rt_data[15:0]};
               2'd2: wb_wdata = {dram_rdata[23:0], rt_data[7:0]};
               default: wb_wdata = dram_rdata;
            endcase
         end
         LD_LWR: begin
            case (addr_lo)
               2'd0: wb_wdata = dram_rdata;
               2'd1: wb_wdata = {rt_data[31:24], dram_rdata[31:8]};
               2'd2: wb_wdata = {rt_data[31:16], dram_rdata[31:16]};
               default: wb_wdata = {rt_data[31:8], dram_rdata[31:24]};
            endcase
         end
         default: wb_wdata = wdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// MEM/WB pipeline register plus write-back. Captures the MEM result each
// rising edge (flush / MEM-only stall insert a bubble, WB stall holds),
// aligns load data from the synchronous RAM, drives the register-file
// write port and owns the committed HI/LO pair.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of mem_wb_stage_if (MEM inputs, RAM data, wb_*, hi_o/lo_o)
import mem_wb_stage_pkg::*;

module mem_wb_stage (
   input  logic           clk,
   input  logic           rst,
   mem_wb_stage_if.slave  bus
);

   stage_t            stage_reg;
   stage_t            stage_next;
   logic [DATA_W-1:0] hi_reg;
   logic [DATA_W-1:0] lo_reg;
   logic [DATA_W-1:0] wdata_aligned;

   always_comb begin
      stage_next = stage_reg;
      if (bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
         stage_next = '0;
      end else if (bus.stall_wb) begin
         stage_next = stage_reg;
      end else begin
         stage_next.waddr   = bus.mem_waddr;
         stage_next.wdata   = bus.mem_wdata;
         stage_next.we      = bus.mem_we;
         stage_next.load_op = load_op_e'(bus.mem_load_op);
         stage_next.addr_lo = bus.mem_wdata[1:0];
         stage_next.rt_data = bus.mem_rt_data;
         stage_next.whilo   = bus.mem_whilo;
         stage_next.hi      = bus.mem_hi;
         stage_next.lo      = bus.mem_lo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_reg <= '0;
         hi_reg    <= ZERO_WORD;
         lo_reg    <= ZERO_WORD;
      end else begin
         stage_reg <= stage_next;
         // The instruction in WB commits HI/LO even if a flush arrives now.
         if (stage_reg.whilo && !bus.stall_wb) begin
            hi_reg <= stage_reg.hi;
            lo_reg <= stage_reg.lo;
         end
      end
   end

   load_align u_load_align (
      .load_op    (stage_reg.load_op),
      .addr_lo    (stage_reg.addr_lo),
      .dram_rdata (bus.dram_rdata),
      .rt_data    (stage_reg.rt_data),
      .wdata      (stage_reg.wdata),
      .wb_wdata   (wdata_aligned)
   );

   assign bus.wb_waddr = stage_reg.waddr;
   assign bus.wb_we    = stage_reg.we;
   assign bus.wb_wdata = wdata_aligned;
   assign bus.wb_whilo = stage_reg.whilo;
   assign bus.wb_hi    = stage_reg.hi;
   assign bus.wb_lo    = stage_reg.lo;
   assign bus.hi_o     = hi_reg;
   assign bus.lo_o     = lo_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Directed literal checks plus a randomized run compared every cycle
// against a behavioural model of the WB stage.
module tb_mem_wb_stage;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   bit   cmp_en;

   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata, m_rt, m_hi, m_lo, m_hi_o, m_lo_o;
   logic        m_we, m_whilo;
   logic [2:0]  m_op;
   logic [1:0]  m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_waddr <= '0; m_wdata <= '0; m_we <= 1'b0; m_op <= '0; m_b <= '0;
         m_rt <= '0; m_whilo <= 1'b0; m_hi <= '0; m_lo <= '0;
         m_hi_o <= '0; m_lo_o <= '0;
      end else begin
         if (m_whilo && !bus.stall_wb) begin
            m_hi_o <= m_hi;
            m_lo_o <= m_lo;
         end
         if (bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
            m_waddr <= '0; m_wdata <= '0; m_we <= 1'b0; m_op <= '0; m_b <= '0;
            m_rt <= '0; m_whilo <= 1'b0; m_hi <= '0; m_lo <= '0;
         end else if (!bus.stall_wb) begin
            m_waddr <= bus.mem_waddr; m_wdata <= bus.mem_wdata;
            m_we <= bus.mem_we; m_op <= bus.mem_load_op;
            m_b <= bus.mem_wdata[1:0]; m_rt <= bus.mem_rt_data;
            m_whilo <= bus.mem_whilo; m_hi <= bus.mem_hi; m_lo <= bus.mem_lo;
         end
      end
   end

   // Expected write-back value from shift/mask arithmetic.
   function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [1:0] b,
                                             input logic [31:0] rt, input logic [31:0] wd,
                                             input logic [31:0] rd);
      logic [63:0] r64, t64, mask;
      int unsigned sh;
      logic [31:0] v;
      r64 = {32'd0, rd};
      t64 = {32'd0, rt};
      v   = wd;
      case (op)
         3'd1, 3'd2: begin
            v = 32'((r64 >> (8 * b)) & 64'hFF);
            if (op == 3'd1 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         end
         3'd3, 3'd4: begin
            v = 32'((r64 >> (16 * (b / 2))) & 64'hFFFF);
            if (op == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         3'd5: v = rd;
         3'd6: begin
            sh   = 8 * (3 - b);
            mask = (64'd1 << sh) - 64'd1;
            v    = 32'((r64 << sh) | (t64 & mask));
         end
         3'd7: begin
            sh   = 8 * b;
            mask = ~((64'd1 << (32 - sh)) - 64'd1);
            v    = 32'((r64 >> sh) | (t64 & mask));
         end
         default: v = wd;
      endcase
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         check("wb_waddr", 32'(bus.wb_waddr), 32'(m_waddr));
         check("wb_we",    32'(bus.wb_we),    32'(m_we));
         check("wb_wdata", bus.wb_wdata, exp_wdata(m_op, m_b, m_rt, m_wdata, bus.dram_rdata));
         check("wb_whilo", 32'(bus.wb_whilo), 32'(m_whilo));
         check("wb_hi",    bus.wb_hi, m_hi);
         check("wb_lo",    bus.wb_lo, m_lo);
         check("hi_o",     bus.hi_o,  m_hi_o);
         check("lo_o",     bus.lo_o,  m_lo_o);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [4:0] wa, input logic [31:0] wd, input logic we,
                        input logic [2:0] op, input logic [31:0] rt, input logic whl,
                        input logic [31:0] hi, input logic [31:0] lo);
      bus.mem_waddr = wa; bus.mem_wdata = wd; bus.mem_we = we; bus.mem_load_op = op;
      bus.mem_rt_data = rt; bus.mem_whilo = whl; bus.mem_hi = hi; bus.mem_lo = lo;
   endtask

   task automatic idle();
      drive(5'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      bus.stall_mem = 1'b0; bus.stall_wb = 1'b0; bus.flush = 1'b0;
   endtask

   // Advance past the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one load, then check the aligned result in its WB cycle.
   task automatic load_case(input string name, input logic [2:0] op, input logic [1:0] b,
                            input logic [31:0] rt, input logic [31:0] rd,
                            input logic [31:0] exp);
      drive(5'd9, {30'h100, b}, 1'b1, op, rt, 1'b0, 32'd0, 32'd0);
      cyc();
      idle();
      bus.dram_rdata = rd;
      #1;
      check(name, bus.wb_wdata, exp);
      $display("load %s b=%0d rd=%08h rt=%08h -> %08h", name, b, rd, rt, bus.wb_wdata);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cmp_en   = 1'b0;
      rst      = 1'b1;
      bus.dram_rdata = 32'd0;
      idle();
      #12;
      rst = 1'b0;
      #1;
      check("reset_wb_we", 32'(bus.wb_we), 32'd0);
      check("reset_wb_wdata", bus.wb_wdata, 32'd0);
      check("reset_hi_o", bus.hi_o, 32'd0);
      cmp_en = 1'b1;

      // ALU result passes through one cycle later.
      drive(5'd5, 32'h1234_5678, 1'b1, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      cyc();
      idle();
      #1;
      check("alu_waddr", 32'(bus.wb_waddr), 32'd5);
      check("alu_wdata", bus.wb_wdata, 32'h1234_5678);
      check("alu_we", 32'(bus.wb_we), 32'd1);
      $display("alu waddr=%0d wdata=%08h we=%0b", bus.wb_waddr, bus.wb_wdata, bus.wb_we);

      load_case("lb_b3",  3'd1, 2'd3, 32'd0, 32'h80FF_7F01, 32'hFFFF_FF80);
      load_case("lbu_b3", 3'd2, 2'd3, 32'd0, 32'h80FF_7F01, 32'h0000_0080);
      load_case("lh_b2",  3'd3, 2'd2, 32'd0, 32'h80FF_7F01, 32'hFFFF_80FF);
      load_case("lhu_b0", 3'd4, 2'd0, 32'd0, 32'h80FF_7F01, 32'h0000_7F01);
      load_case("lw_b0",  3'd5, 2'd0, 32'd0, 32'h80FF_7F01, 32'h80FF_7F01);
      load_case("lwl_b1", 3'd6, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
      load_case("lwr_b2", 3'd7, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);

      // Full stall holds the WB instruction; MEM-only stall inserts a bubble.
      drive(5'd7, 32'hCAFE_0001, 1'b1, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      cyc();
      drive(5'd8, 32'h0BAD_0002, 1'b1, 3'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      bus.stall_mem = 1'b1; bus.stall_wb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("stall_hold_waddr", 32'(bus.wb_waddr), 32'd7);
         check("stall_hold_wdata", bus.wb_wdata, 32'hCAFE_0001);
         check("stall_hold_we", 32'(bus.wb_we), 32'd1);
         $display("stall cycle %0d waddr=%0d wdata=%08h", i, bus.wb_waddr, bus.wb_wdata);
      end
      bus.stall_wb = 1'b0;
      cyc();
      check("bubble_we", 32'(bus.wb_we), 32'd0);
      check("bubble_waddr", 32'(bus.wb_waddr), 32'd0);
      $display("bubble we=%0b", bus.wb_we);
      idle();

      // HI/LO: visible in WB next cycle, committed one edge later despite flush.
      drive(5'd0, 32'd0, 1'b0, 3'd0, 32'd0, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF);
      cyc();
      idle();
      bus.flush = 1'b1;
      #1;
      check("whilo_wb", 32'(bus.wb_whilo), 32'd1);
      check("whilo_wb_hi", bus.wb_hi, 32'hDEAD_0000);
      check("whilo_wb_lo", bus.wb_lo, 32'h0000_BEEF);
      check("whilo_hi_o_pre", bus.hi_o, 32'd0);
      cyc();
      bus.flush = 1'b0;
      check("whilo_hi_o", bus.hi_o, 32'hDEAD_0000);
      check("whilo_lo_o", bus.lo_o, 32'h0000_BEEF);
      check("flush_wb_whilo", 32'(bus.wb_whilo), 32'd0);
      $display("hilo commit hi=%08h lo=%08h", bus.hi_o, bus.lo_o);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         drive(5'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
               1'($urandom), $urandom, $urandom);
         bus.stall_mem  = ($urandom_range(0, 3) == 0);
         bus.stall_wb   = ($urandom_range(0, 3) == 0);
         bus.flush      = ($urandom_range(0, 9) == 0);
         bus.dram_rdata = $urandom;
         $display("rand %0d op=%0d wa=%0d wd=%08h sm=%0b sw=%0b fl=%0b", i,
                  bus.mem_load_op, bus.mem_waddr, bus.mem_wdata,
                  bus.stall_mem, bus.stall_wb, bus.flush);
         cyc();
      end

      // Asynchronous reset mid-cycle with a loaded stage and HI/LO set.
      idle();
      drive(5'd3, 32'h5555_AAAA, 1'b1, 3'd0, 32'd0, 1'b1, 32'h1111_1111, 32'h2222_2222);
      cyc();
      cyc();
      idle();
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_we", 32'(bus.wb_we), 32'd0);
      check("async_rst_waddr", 32'(bus.wb_waddr), 32'd0);
      check("async_rst_wdata", bus.wb_wdata, 32'd0);
      check("async_rst_whilo", 32'(bus.wb_whilo), 32'd0);
      check("async_rst_hi_o", bus.hi_o, 32'd0);
      check("async_rst_lo_o", bus.lo_o, 32'd0);
      $display("async reset we=%0b hi_o=%08h", bus.wb_we, bus.hi_o);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 50; i++) begin
         drive(5'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
               1'($urandom), $urandom, $urandom);
         bus.stall_mem  = ($urandom_range(0, 3) == 0);
         bus.stall_wb   = ($urandom_range(0, 3) == 0);
         bus.flush      = ($urandom_range(0, 9) == 0);
         bus.dram_rdata = $urandom;
         $display("rand2 %0d op=%0d wd=%08h", i, bus.mem_load_op, bus.mem_wdata);
         cyc();
      end
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
